// File: rtl/wb_queue.sv
// wb_queue: write-back stage with an in-order outstanding-load queue.
// Loads push their destination register into a FIFO and write back when
// memory returns data. ALU/LI results write back directly. A one-entry skid
// holds an ALU/LI result that collides with a load return. Register hazards
// are blocked at the input through the pending mask.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_valid/ready  upstream handshake for an instruction result
//   in_instr        16-bit instruction word (class and destination decode)
//   in_result       ALU/shift/LI result
//   mem_rvalid      load data return (in issue order), mem_rdata payload
//   rf_we/waddr/wdata  registered register-file write port
//   pending         bit r set while a queued load targets register r
//   lq_count        loads outstanding; lq_full when lq_count == DEPTH
//   err_unexpected  sticky: load data returned with an empty queue
module wb_queue #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [15:0]              in_instr,
  input  logic [WIDTH-1:0]         in_result,
  input  logic                     mem_rvalid,
  input  logic [WIDTH-1:0]         mem_rdata,
  output logic                     rf_we,
  output logic [2:0]               rf_waddr,
  output logic [WIDTH-1:0]         rf_wdata,
  output logic [7:0]               pending,
  output logic [$clog2(DEPTH):0]   lq_count,
  output logic                     lq_full,
  output logic                     err_unexpected
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {CLS_NONE, CLS_LD, CLS_ALU, CLS_LI} instr_class_t;

  instr_class_t     cls;
  logic [2:0]       dest;
  logic [2:0]       q_dest [DEPTH];
  logic [AW-1:0]    head_q, tail_q;
  logic [AW:0]      count_q;
  logic             skid_v;
  logic [2:0]       skid_addr;
  logic [WIDTH-1:0] skid_data;
  logic             pop, push, acc_wr;

  assign dest = in_instr[10:8];

  always_comb begin
    cls = CLS_NONE;
    if (in_instr[15:14] == 2'b00)
      cls = CLS_LD;
    else if (in_instr[15:14] == 2'b11 &&
             !(in_instr[7:4] inside {4'b0101, 4'b1101, 4'b1110, 4'b1111}))
      cls = CLS_ALU;
    else if (in_instr[15:11] == 5'b10000)
      cls = CLS_LI;
  end

  assign lq_count = count_q;
  assign lq_full  = (count_q == (AW+1)'(DEPTH));

  // Pending mask comes only from registered queue state, so a pop clears its
  // bit at the same edge and mem_rvalid never reaches in_ready combinationally.
  always_comb begin
    pending = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (i < 32'(count_q))
        pending[q_dest[head_q + AW'(i)]] = 1'b1;
    end
  end

  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      unique case (cls)
        CLS_NONE:        in_ready = 1'b1;
        CLS_LD:          in_ready = !lq_full && !skid_v;
        CLS_ALU, CLS_LI: in_ready = !pending[dest] && !skid_v;
        default:         in_ready = 1'b0;
      endcase
    end
  end

  assign pop    = mem_rvalid && (count_q != '0);
  assign push   = in_valid && in_ready && (cls == CLS_LD);
  assign acc_wr = in_valid && in_ready && (cls == CLS_ALU || cls == CLS_LI);

  always_ff @(posedge clk) begin
    if (push)
      q_dest[tail_q] <= dest;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      skid_v         <= 1'b0;
      skid_addr      <= '0;
      skid_data      <= '0;
      rf_we          <= 1'b0;
      rf_waddr       <= '0;
      rf_wdata       <= '0;
      err_unexpected <= 1'b0;
    end else begin
      if (push)
        tail_q <= tail_q + AW'(1);
      if (pop)
        head_q <= head_q + AW'(1);
      if (push && !pop)
        count_q <= count_q + (AW+1)'(1);
      else if (pop && !push)
        count_q <= count_q - (AW+1)'(1);
      if (mem_rvalid && count_q == '0)
        err_unexpected <= 1'b1;

      // Write port priority: load return, then skid, then new ALU/LI.
      if (pop) begin
        rf_we    <= 1'b1;
        rf_waddr <= q_dest[head_q];
        rf_wdata <= mem_rdata;
        if (acc_wr) begin
          skid_v    <= 1'b1;
          skid_addr <= dest;
          skid_data <= in_result;
        end
      end else if (skid_v) begin
        rf_we    <= 1'b1;
        rf_waddr <= skid_addr;
        rf_wdata <= skid_data;
        skid_v   <= 1'b0;
      end else if (acc_wr) begin
        rf_we    <= 1'b1;
        rf_waddr <= dest;
        rf_wdata <= in_result;
      end else begin
        rf_we <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue (WIDTH=16, DEPTH=4).
module tb_wb_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic [15:0] in_result;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic [7:0]  pending;
  logic [2:0]  lq_count;
  logic        lq_full;
  logic        err_unexpected;

  int checks = 0;
  int errors = 0;

  wb_queue #(.WIDTH(16), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_result(in_result),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pending(pending), .lq_count(lq_count), .lq_full(lq_full),
    .err_unexpected(err_unexpected)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [15:0] instr, input logic [15:0] res);
    in_valid  = 1'b1;
    in_instr  = instr;
    in_result = res;
    #1;
  endtask

  task automatic check_wr(input string tag, input logic [2:0] a, input logic [15:0] d);
    check({tag, "_we"}, rf_we, 1);
    check({tag, "_addr"}, rf_waddr, a);
    check({tag, "_data"}, rf_wdata, d);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0; mem_rvalid = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = 16'h4000; in_result = '0;
    mem_rvalid = 1'b0; mem_rdata = '0;
    tick(); tick();
    check("rst_ready", in_ready, 0);
    check("rst_we", rf_we, 0);
    check("rst_waddr", rf_waddr, 0);
    check("rst_wdata", rf_wdata, 0);
    check("rst_count", lq_count, 0);
    check("rst_full", lq_full, 0);
    check("rst_pending", pending, 0);
    check("rst_err", err_unexpected, 0);
    rst = 1'b0;

    // LI r3 writes back one cycle after acceptance
    offer(16'h8305, 16'h1234);
    check("li_ready", in_ready, 1);
    tick(); in_valid = 1'b0;
    check_wr("li", 3'd3, 16'h1234);
    tick();
    check("li_idle_we", rf_we, 0);
    check("li_hold_data", rf_wdata, 16'h1234);

    // NONE is accepted and changes nothing
    offer(16'h4000, 16'hFFFF);
    check("none_ready", in_ready, 1);
    tick(); in_valid = 1'b0;
    check("none_we", rf_we, 0);
    check("none_count", lq_count, 0);

    // Fill the load queue with r1..r4
    for (int i = 1; i <= 4; i++) begin
      offer(16'(i << 8), 16'h0);
      check("ld_ready", in_ready, 1);
      tick();
    end
    in_valid = 1'b0;
    check("full_count", lq_count, 4);
    check("full_flag", lq_full, 1);
    check("full_pending", pending, 8'h1E);
    check("full_no_we", rf_we, 0);
    // Fifth LD stays blocked even with a pop this cycle
    mem_rvalid = 1'b1; mem_rdata = 16'h000A;
    offer(16'h0500, 16'h0);
    check("ld5_ready", in_ready, 0);
    tick(); in_valid = 1'b0;
    check_wr("pop1", 3'd1, 16'h000A);
    check("pop1_pending", pending, 8'h1C);
    check("pop1_count", lq_count, 3);
    for (int i = 2; i <= 4; i++) begin
      mem_rdata = 16'(9 + i);
      tick();
      check_wr("popn", 3'(i), 16'(9 + i));
    end
    mem_rvalid = 1'b0;
    tick();
    check("drain_we", rf_we, 0);
    check("drain_count", lq_count, 0);
    check("drain_full", lq_full, 0);
    check("drain_err", err_unexpected, 0);

    // Hazard on r5 with an outstanding load; r6 unaffected
    offer(16'h0500, 16'h0);
    tick();
    check("r5_pending", pending, 8'h20);
    offer(16'hC500, 16'h5555);
    check("haz_r5_ready", in_ready, 0);
    tick();
    check("haz_r5_ready2", in_ready, 0);
    check("haz_r5_we", rf_we, 0);
    offer(16'hC600, 16'h6666);
    check("r6_ready", in_ready, 1);
    tick();
    check_wr("r6", 3'd6, 16'h6666);
    offer(16'hC500, 16'h5555);
    mem_rvalid = 1'b1; mem_rdata = 16'h0505;
    #1;
    check("haz_pop_ready", in_ready, 0);
    tick(); mem_rvalid = 1'b0; #1;
    check_wr("ld_r5", 3'd5, 16'h0505);
    check("r5_after_pop_ready", in_ready, 1);
    tick(); in_valid = 1'b0;
    check_wr("alu_r5", 3'd5, 16'h5555);

    // ALU collides with load pop: skid defers it one cycle
    offer(16'h0100, 16'h0);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 16'h00AA;
    offer(16'hC200, 16'h0055);
    check("coll_ready", in_ready, 1);
    tick();
    mem_rvalid = 1'b0; in_valid = 1'b0; in_instr = 16'hC700; #1;
    check_wr("coll_ld", 3'd1, 16'h00AA);
    check("skid_ready", in_ready, 0);
    tick();
    check_wr("coll_skid", 3'd2, 16'h0055);
    check("skid_free_ready", in_ready, 1);

    // Unexpected load data
    mem_rvalid = 1'b1; mem_rdata = 16'hDEAD;
    tick(); mem_rvalid = 1'b0;
    check("unexp_we", rf_we, 0);
    check("unexp_err", err_unexpected, 1);
    tick();
    check("unexp_sticky", err_unexpected, 1);

    // Reset discards queued loads and a full skid
    do_reset();
    check("rst2_err", err_unexpected, 0);
    for (int i = 1; i <= 4; i++) begin
      offer(16'(i << 8), 16'h0);
      tick();
    end
    mem_rvalid = 1'b1; mem_rdata = 16'h00F1;
    offer(16'hC700, 16'h7777);
    tick(); in_valid = 1'b0;
    check("pre_rst_count", lq_count, 3);
    check("pre_rst_pending", pending, 8'h1C);
    rst = 1'b1;
    tick();
    check("mid_rst_count", lq_count, 0);
    check("mid_rst_pending", pending, 0);
    check("mid_rst_we", rf_we, 0);
    check("mid_rst_err", err_unexpected, 0);
    rst = 1'b0; mem_rvalid = 1'b0;
    tick();
    check("post_rst_no_skid", rf_we, 0);
    mem_rvalid = 1'b1;
    tick(); mem_rvalid = 1'b0;
    check("post_rst_err", err_unexpected, 1);
    check("post_rst_we", rf_we, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
